// File: rtl/mem_req_queue.sv
// In-order request queue in front of mem_system: buffers requests, issues one at a time,
// rejects misaligned addresses and times out stuck accesses. Optional counters: MEM_REQ_QUEUE_STATS_EN.
`timescale 1ns/1ps
module mem_req_queue #(
   parameter int DEPTH = 4,
   parameter int TMO   = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   input  logic        mem_stall,
   input  logic        mem_hit,
   output logic        rsp_valid,
   output logic        rsp_wr,
   output logic [15:0] rsp_data,
   output logic        rsp_hit,
   output logic        rsp_err,
   output logic        tmo_flag,
   output logic [15:0] stat_req,
   output logic [15:0] stat_hit
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TMO + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_CNT  = TW'(TMO);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [32:0]   fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ready_en;
   logic [1:0]    state;
   logic [TW-1:0] busy_cnt;

   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          head_wr;
   logic [15:0]   head_addr;
   logic [15:0]   head_wdata;
   logic          issue;
   logic          misalign;
   logic          done_evt;
   logic          tmo_evt;

   // Ready comes only from registered state, so a pop in the same cycle never frees a full queue.
   assign req_ready  = ready_en && (count != FULL_CNT);
   assign push       = req_valid && req_ready;
   assign fifo_empty = (count == '0);
   assign {head_wr, head_addr, head_wdata} = fifo_mem[rd_ptr];

   assign issue    = (state == IDLE) && !fifo_empty && !mem_stall && !head_addr[0];
   assign misalign = (state == IDLE) && !fifo_empty && head_addr[0];
   assign done_evt = (state == BUSY) && mem_done;
   assign tmo_evt  = (state == BUSY) && !mem_done && (busy_cnt == TMO_CNT);
   assign pop      = misalign || done_evt || tmo_evt;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {req_wr, req_addr, req_wdata};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // The head entry stays queued while in flight; it is popped only on completion or timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy_cnt  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tmo_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (misalign) begin
                  state <= RESP;
               end else if (issue) begin
                  state     <= BUSY;
                  busy_cnt  <= TW'(1);
                  mem_rd    <= !head_wr;
                  mem_wr    <= head_wr;
                  mem_addr  <= head_addr;
                  mem_wdata <= head_wdata;
               end
            end
            BUSY: begin
               if (done_evt || tmo_evt) begin
                  state  <= RESP;
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
               end
               if (tmo_evt) begin
                  tmo_flag <= 1'b1;
               end
               if (busy_cnt != TMO_CNT) begin
                  busy_cnt <= busy_cnt + TW'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Response fields are registered alongside the transition into RESP so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_err   <= 1'b0;
         if (misalign || tmo_evt) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= head_wr;
            rsp_err   <= 1'b1;
         end else if (done_evt) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= head_wr;
            rsp_hit   <= mem_hit;
            rsp_data  <= head_wr ? 16'h0000 : mem_rdata;
         end
      end
   end

`ifdef MEM_REQ_QUEUE_STATS_EN
   // Only completed accesses count; misaligned and timed-out requests are errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_req <= '0;
         stat_hit <= '0;
      end else if (done_evt) begin
         if (stat_req != 16'hFFFF) begin
            stat_req <= stat_req + 16'd1;
         end
         if (mem_hit && (stat_hit != 16'hFFFF)) begin
            stat_hit <= stat_hit + 16'd1;
         end
      end
   end
`else
   assign stat_req = '0;
   assign stat_hit = '0;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a vector table for the basic read/write/misaligned flow,
// then hand-written sequences for full queue, stall, timeout and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_req_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_done = 1'b0;
   logic        mem_stall = 1'b0;
   logic        mem_hit = 1'b0;
   logic        rsp_valid;
   logic        rsp_wr;
   logic [15:0] rsp_data;
   logic        rsp_hit;
   logic        rsp_err;
   logic        tmo_flag;
   logic [15:0] stat_req;
   logic [15:0] stat_hit;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_req_queue #(.DEPTH(4), .TMO(31)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
      .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
      .rsp_err(rsp_err), .tmo_flag(tmo_flag), .stat_req(stat_req), .stat_hit(stat_hit)
   );

   typedef struct {
      logic        rv;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        done;
      logic        hit;
      logic        e_ready;
      logic        e_rd;
      logic        e_wr;
      logic [15:0] e_addr;
      logic [15:0] e_wdata;
      logic        e_rv;
      logic [15:0] e_rdata;
      logic        e_rhit;
      logic        e_rerr;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [15:0] b16(input logic x);
      return {15'd0, x};
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      req_valid = v.rv;
      req_wr    = v.rw;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      mem_rdata = v.rdata;
      mem_done  = v.done;
      mem_hit   = v.hit;
   endtask

   // Waits (bounded) for an issue, checks it, completes it and checks the response.
   task automatic serviceOne(input logic [15:0] exp_addr, input logic exp_wr, input logic hit);
      int waited = 0;
      while (!(mem_rd || mem_wr) && waited < 40) begin
         step();
         waited++;
      end
      checkOutput("svc.issued", b16(mem_rd || mem_wr), 16'd1);
      checkOutput("svc.addr", mem_addr, exp_addr);
      checkOutput("svc.wr", b16(mem_wr), b16(exp_wr));
      checkOutput("svc.rd", b16(mem_rd), b16(!exp_wr));
      mem_done  = 1'b1;
      mem_hit   = hit;
      mem_rdata = ~exp_addr;
      step();
      mem_done = 1'b0;
      mem_hit  = 1'b0;
      checkOutput("svc.rsp_valid", b16(rsp_valid), 16'd1);
      checkOutput("svc.rsp_data", rsp_data, exp_wr ? 16'h0000 : ~exp_addr);
      checkOutput("svc.rsp_hit", b16(rsp_hit), b16(hit));
      checkOutput("svc.rsp_err", b16(rsp_err), 16'd0);
      checkOutput("svc.mem_idle", b16(mem_rd || mem_wr), 16'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      int bad;

      // rv rw addr wdata rdata done hit | ready rd wr addr wdata rv rdata rhit rerr
      vecs[0]  = '{1, 0, 16'h6004, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[1]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[2]  = '{0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 1, 1, 1, 0, 16'h6004, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1, 0};
      vecs[4]  = '{1, 1, 16'h2000, 16'h1234, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[5]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[6]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 1, 16'h2000, 16'h1234, 0, 16'h0000, 0, 0};
      vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 1, 16'h2000, 16'h1234, 0, 16'h0000, 0, 0};
      vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0};
      vecs[9]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[10] = '{1, 1, 16'h1235, 16'hAAAA, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[11] = '{1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[12] = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 1};
      vecs[13] = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[14] = '{0, 0, 16'h0000, 16'h0000, 16'h5A5A, 1, 1, 1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0};
      vecs[15] = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h5A5A, 1, 0};
      vecs[16] = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};

      #1 rst_n = 1'b0;
      repeat (2) step();
      checkOutput("rst.req_ready", b16(req_ready), 16'd0);
      checkOutput("rst.mem_rd", b16(mem_rd), 16'd0);
      checkOutput("rst.mem_wr", b16(mem_wr), 16'd0);
      checkOutput("rst.mem_addr", mem_addr, 16'h0000);
      checkOutput("rst.rsp_valid", b16(rsp_valid), 16'd0);
      checkOutput("rst.tmo_flag", b16(tmo_flag), 16'd0);
      checkOutput("rst.stat_req", stat_req, 16'h0000);
      rst_n = 1'b1;
      checkOutput("rst.ready_before_edge", b16(req_ready), 16'd0);
      step();
      checkOutput("rst.ready_after_edge", b16(req_ready), 16'd1);

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d.ready", i), b16(req_ready), b16(vecs[i].e_ready));
         checkOutput($sformatf("v%0d.mem_rd", i), b16(mem_rd), b16(vecs[i].e_rd));
         checkOutput($sformatf("v%0d.mem_wr", i), b16(mem_wr), b16(vecs[i].e_wr));
         checkOutput($sformatf("v%0d.rsp_valid", i), b16(rsp_valid), b16(vecs[i].e_rv));
         if (vecs[i].e_rd || vecs[i].e_wr) begin
            checkOutput($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
            checkOutput($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         end
         if (vecs[i].e_rv) begin
            checkOutput($sformatf("v%0d.rsp_data", i), rsp_data, vecs[i].e_rdata);
            checkOutput($sformatf("v%0d.rsp_hit", i), b16(rsp_hit), b16(vecs[i].e_rhit));
            checkOutput($sformatf("v%0d.rsp_err", i), b16(rsp_err), b16(vecs[i].e_rerr));
         end
         step();
      end
      req_valid = 1'b0;
      mem_done  = 1'b0;
      mem_hit   = 1'b0;

      // Fill the queue with the head in flight; the fifth push waits for the first response.
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_wr    = 1'b0;
         req_addr  = 16'h0100 + 16'(2 * i);
         checkOutput($sformatf("full.ready%0d", i), b16(req_ready), 16'd1);
         step();
      end
      req_addr = 16'h0108;
      for (int i = 0; i < 3; i++) begin
         checkOutput("full.ready_low", b16(req_ready), 16'd0);
         step();
      end
      checkOutput("full.head_rd", b16(mem_rd), 16'd1);
      checkOutput("full.head_addr", mem_addr, 16'h0100);
      mem_done  = 1'b1;
      mem_rdata = 16'h1111;
      checkOutput("full.ready_at_pop", b16(req_ready), 16'd0);
      step();
      mem_done = 1'b0;
      checkOutput("full.rsp_valid", b16(rsp_valid), 16'd1);
      checkOutput("full.rsp_data", rsp_data, 16'h1111);
      checkOutput("full.ready_after_pop", b16(req_ready), 16'd1);
      step();
      req_valid = 1'b0;
      checkOutput("full.ready_after_fifth", b16(req_ready), 16'd0);
      serviceOne(16'h0102, 1'b0, 1'b1);
      serviceOne(16'h0104, 1'b0, 1'b1);
      serviceOne(16'h0106, 1'b0, 1'b1);
      serviceOne(16'h0108, 1'b0, 1'b1);
      repeat (3) step();
      checkOutput("full.drained_ready", b16(req_ready), 16'd1);
      checkOutput("full.drained_idle", b16(mem_rd || mem_wr), 16'd0);

      // Stall held for ten cycles blocks issue; release issues on the next edge.
      mem_stall = 1'b1;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h0200;
      step();
      req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (mem_rd || mem_wr) bad++;
      end
      checkOutput("stall.no_issue", 16'(bad), 16'd0);
      mem_stall = 1'b0;
      step();
      checkOutput("stall.issue_next", b16(mem_rd), 16'd1);
      checkOutput("stall.addr", mem_addr, 16'h0200);
      serviceOne(16'h0200, 1'b0, 1'b0);

      // Withheld mem_done: still busy in the 31st busy cycle, timeout response right after.
      req_valid = 1'b1;
      req_addr  = 16'h0300;
      step();
      req_valid = 1'b0;
      waited = 0;
      while (!mem_rd && waited < 10) begin
         step();
         waited++;
      end
      checkOutput("tmo.issued", b16(mem_rd), 16'd1);
      for (int i = 0; i < 30; i++) step();
      checkOutput("tmo.rd_at_31", b16(mem_rd), 16'd1);
      checkOutput("tmo.flag_at_31", b16(tmo_flag), 16'd0);
      step();
      checkOutput("tmo.flag", b16(tmo_flag), 16'd1);
      checkOutput("tmo.rsp_valid", b16(rsp_valid), 16'd1);
      checkOutput("tmo.rsp_err", b16(rsp_err), 16'd1);
      checkOutput("tmo.rd_low", b16(mem_rd), 16'd0);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      checkOutput("tmo.single_rsp", b16(rsp_valid), 16'd0);
      checkOutput("tmo.sticky", b16(tmo_flag), 16'd1);
      step();
      checkOutput("tmo.late_done_ignored", b16(mem_rd || mem_wr || rsp_valid), 16'd0);

`ifdef MEM_REQ_QUEUE_STATS_EN
      checkOutput("stats.req", stat_req, 16'd9);
      checkOutput("stats.hit", stat_hit, 16'd6);
`else
      checkOutput("stats.req", stat_req, 16'd0);
      checkOutput("stats.hit", stat_hit, 16'd0);
`endif

      // Reset in the middle of a write: everything clears without a clock edge.
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'h0400;
      req_wdata = 16'h7777;
      step();
      req_valid = 1'b0;
      waited = 0;
      while (!mem_wr && waited < 10) begin
         step();
         waited++;
      end
      checkOutput("rstmid.busy", b16(mem_wr), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstmid.mem_wr", b16(mem_wr), 16'd0);
      checkOutput("rstmid.mem_addr", mem_addr, 16'h0000);
      checkOutput("rstmid.mem_wdata", mem_wdata, 16'h0000);
      checkOutput("rstmid.req_ready", b16(req_ready), 16'd0);
      checkOutput("rstmid.tmo_flag", b16(tmo_flag), 16'd0);
      checkOutput("rstmid.stat_req", stat_req, 16'h0000);
      checkOutput("rstmid.stat_hit", stat_hit, 16'h0000);
      repeat (2) step();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid || mem_wr || mem_rd) bad++;
      end
      checkOutput("rstmid.no_rsp", 16'(bad), 16'd0);
      checkOutput("rstmid.ready", b16(req_ready), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, FIFO entries (power of 2, 2..8); TMO, default 31, max cycles from issue to mem_done before timeout.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1, req_wr  in  1, req_addr  in  16, req_wdata  in  16 (upstream request).
REQ-005 SHALL have ports: req_ready  out  1  request accepted when req_valid&req_ready at clk edge.
REQ-006 SHALL have ports: mem_rd  out  1, mem_wr  out  1, mem_addr  out  16, mem_wdata  out  16 (to mem_system Rd/Wr/Addr/DataIn).
REQ-007 SHALL have ports: mem_rdata  in  16, mem_done  in  1, mem_stall  in  1, mem_hit  in  1 (from mem_system DataOut/Done/Stall/CacheHit).
REQ-008 SHALL have ports: rsp_valid  out  1, rsp_wr  out  1, rsp_data  out  16, rsp_hit  out  1, rsp_err  out  1 (one-cycle response).
REQ-009 SHALL have ports: tmo_flag  out  1  sticky timeout; stat_req  out  16, stat_hit  out  16 (counters).

Function
REQ-010 SHALL buffer requests {wr,addr,wdata} in an in-order FIFO of DEPTH entries; req_ready = not full.
REQ-011 SHALL, when full, hold req_ready low; a simultaneous pop and push when full SHALL NOT be accepted (ready decided on registered count).
REQ-012 SHALL run FSM IDLE/BUSY/RESP; reset state IDLE.
REQ-013 IDLE->BUSY when FIFO non-empty and mem_stall=0 and head addr[0]=0: drive head onto mem_* with mem_rd=~wr, mem_wr=wr from the next cycle.
REQ-014 IDLE with head addr[0]=1 (misaligned): pop head, not issued, next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-015 BUSY SHALL hold mem_rd/mem_wr/mem_addr/mem_wdata stable through the cycle mem_done=1 inclusive.
REQ-016 BUSY with mem_done=1: capture mem_rdata (reads) and mem_hit, pop FIFO, go RESP; mem_rd/mem_wr low the following cycle.
REQ-017 RESP SHALL assert rsp_valid for exactly one cycle with rsp_wr, rsp_hit, rsp_data (0 for writes), rsp_err=0, then IDLE.
REQ-018 Minimum issue gap: a new request SHALL NOT be issued in the RESP cycle; back-to-back hits give one response per 3 cycles.
REQ-019 BUSY cycle counter SHALL saturate at TMO; reaching TMO without mem_done: set tmo_flag, pop head, deassert mem_rd/mem_wr, RESP with rsp_err=1.
REQ-020 mem_done arriving in IDLE or RESP SHALL be ignored.
REQ-021 mem_rd and mem_wr SHALL never be high simultaneously.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1.

Reset
REQ-023 rst_n low SHALL immediately: FIFO empty, FSM IDLE, req_ready=0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, rsp_*=0, tmo_flag=0, stat_*=0.
REQ-024 req_ready SHALL rise the first clk edge after rst_n deasserts; reset mid-transaction discards the in-flight request with no response.

Configuration
REQ-025 MEM_REQ_QUEUE_STATS_EN defined: stat_req increments per RESP with rsp_err=0; stat_hit additionally when rsp_hit=1; both saturate at 16'hFFFF.
REQ-026 MEM_REQ_QUEUE_STATS_EN undefined: stat_req and stat_hit SHALL be constant 0 and counter logic absent.

Verification
REQ-027 Read 0x6004, mem model done+hit 1 cycle after issue, rdata 0xBEEF -> one rsp_valid, rsp_data=0xBEEF, rsp_hit=1, rsp_err=0.
REQ-028 Push 5 requests without mem_done (DEPTH=4) -> req_ready low after 4th; 5th accepted only after first response.
REQ-029 Write 0x1235 (odd) -> no mem_wr ever, rsp_valid with rsp_err=1, next queued request issues normally.
REQ-030 Read with mem_done withheld -> at 31 cycles tmo_flag=1, rsp_err=1, mem_rd low next cycle.
REQ-031 mem_stall held high 10 cycles with FIFO non-empty -> no issue until stall drops; then issue next cycle.
REQ-032 rst_n low while BUSY -> all outputs 0 asynchronously, no rsp_valid after release; stats (STATS_EN) read 0.
